timer_alarm: RTL and testbench
==============================

# timer_alarm

Compare/alarm stage placed directly downstream of the 64-bit free-running timer core. It consumes the live counter value, compares it against a programmable 64-bit target and raises a level interrupt on match. A compiled-in option adds periodic auto-reload with overrun detection. Software drives it through its register file, which sits alongside the timer's own registers.

## Interface
- CNT_W, 64, counter/target/period width; must equal 2*DATA_W of the timer
- MCNT_W, 16, width of the match counter
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (clears all state when 0)
- cnt_value  input  CNT_W  live counter value from the timer core
- cmp_wdata  input  CNT_W  new target value
- cmp_load  input  1  one-cycle pulse: target <= cmp_wdata
- period  input  CNT_W  reload increment (periodic mode only)
- periodic  input  1  1 = periodic mode, 0 = one-shot; sampled on arm
- arm  input  1  one-cycle pulse: enter ARMED
- disarm  input  1  one-cycle pulse: enter IDLE
- irq_ack  input  1  one-cycle pulse: clear irq and missed
- irq  output  1  registered interrupt request, level
- state  output  2  current FSM state (IDLE=0, ARMED=1, FIRED=2)
- match_count  output  MCNT_W  number of matches since reset, saturating
- missed  output  1  sticky overrun flag (periodic only)
- target  output  CNT_W  current target, for readback

## Operation
- Match condition (combinational): hit = ARMED and signed(cnt_value - target) >= 0, difference taken modulo 2^CNT_W; a target up to 2^(CNT_W-1)-1 ticks ahead is treated as future, so counter wrap is handled.
- FSM: IDLE -arm-> ARMED; ARMED -hit, one-shot-> FIRED; ARMED -hit, periodic-> ARMED; FIRED -irq_ack-> IDLE; FIRED -arm-> ARMED; any state -disarm-> IDLE.
- Mode latched into mode_q on arm; changing periodic while ARMED has no effect.
- On hit: irq <= 1; match_count increments, holding at all-ones.
- Periodic hit: target <= target + period (mod 2^CNT_W). If period == 0, the hit behaves as one-shot (enters FIRED).
- Overrun: on a periodic hit, if the new target is also already reached (signed(cnt_value - (target+period)) >= 0), missed <= 1. Target is still advanced by exactly one period; no catch-up loop.
- cmp_load in any state updates target; the FSM state is unchanged.
- irq_ack clears irq and missed; the FSM moves from FIRED to IDLE.
- Priority within one cycle: disarm > arm > hit. If hit and irq_ack coincide, irq stays 1, missed is cleared, and match_count increments. If cmp_load and a periodic reload coincide, cmp_load wins.

## Timing
- Reset values: irq=0, state=IDLE, match_count=0, missed=0, target=all-ones, mode_q=0.
- Latency: cnt_value reaching target in cycle N -> irq=1 and state updated after edge N+1 (one register stage). No combinational path from inputs to outputs.
- arm in cycle N: comparison is active from cycle N+1. A target already passed fires at edge N+2.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Pulses coinciding with reset deassertion are ignored.

## Configuration
- TIMER_ALARM_PERIODIC_EN defined: periodic input, period reload, and missed logic are present as described.
- Undefined: the periodic and period inputs are ignored, mode_q is forced to 0, every hit goes to FIRED, missed is tied to 0, and the adder is removed.

## Structure
- Shared package/header (timer_alarm.vh): state encodings ST_IDLE/ST_ARMED/ST_FIRED, CNT_W and MCNT_W defaults, and register addresses for TARGET_LOW/HIGH, PERIOD_LOW/HIGH, CTRL (arm/disarm/periodic), STATUS (irq/missed/state), ACK, and MATCH_CNT.
- One sub-module, timer_alarm_cmp: purely combinational wrap-safe "reached" comparator (inputs a and b; output is sign bit of a-b inverted). It is instantiated twice: once for the hit check and once for the overrun check.

## Test plan
- One-shot: target=100, arm at cnt=90 -> irq rises on the edge after cnt=100, state=FIRED, match_count=1; irq_ack -> irq=0, state=IDLE.
- Wrap: target=0x0000_0000_0000_0005, arm at cnt=0xFFFF_FFFF_FFFF_FFF0 -> no irq before wrap; irq one cycle after cnt=5.
- Periodic: target=50, period=20, cnt running -> hits at 50, 70, 90; target readback=110 after the third hit; missed=0.
- Overrun: periodic, period=1, cnt advancing 1 per cycle after being held and then stepped by 3 -> missed=1; irq_ack -> missed=0.
- Same-cycle conflicts: arm+disarm -> IDLE. A hit coinciding with irq_ack -> irq stays 1 and match_count increments.
- Reset mid-ARMED with irq=1 -> all outputs at reset values in the same cycle; no irq after release until re-armed. Repeat with TIMER_ALARM_PERIODIC_EN undefined -> periodic request yields FIRED.

Source files
------------

// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer compare/alarm stage: widths, FSM encoding and register map.
package timer_alarm_pkg;

  localparam int CNT_W  = 64;
  localparam int MCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  // Byte offsets inside the timer register file, after the timer core's own registers.
  localparam logic [7:0] ADDR_TARGET_LOW  = 8'h40;
  localparam logic [7:0] ADDR_TARGET_HIGH = 8'h44;
  localparam logic [7:0] ADDR_PERIOD_LOW  = 8'h48;
  localparam logic [7:0] ADDR_PERIOD_HIGH = 8'h4C;
  localparam logic [7:0] ADDR_CTRL        = 8'h50;
  localparam logic [7:0] ADDR_STATUS      = 8'h54;
  localparam logic [7:0] ADDR_ACK         = 8'h58;
  localparam logic [7:0] ADDR_MATCH_CNT   = 8'h5C;

  localparam int CTRL_ARM_BIT      = 0;
  localparam int CTRL_DISARM_BIT   = 1;
  localparam int CTRL_PERIODIC_BIT = 2;

  localparam int STATUS_IRQ_BIT    = 0;
  localparam int STATUS_MISSED_BIT = 1;
  localparam int STATUS_STATE_LSB  = 2;

  function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
    return (&v) ? v : v + MCNT_W'(1);
  endfunction

endpackage

// File: rtl/timer_alarm_if.sv
// Software-facing control/status bundle of the alarm stage; master = register file, slave = alarm.
interface timer_alarm_if #(
  parameter int CNT_W  = timer_alarm_pkg::CNT_W,
  parameter int MCNT_W = timer_alarm_pkg::MCNT_W
);

  logic [CNT_W-1:0]  cmp_wdata;
  logic              cmp_load;
  logic [CNT_W-1:0]  period;
  logic              periodic;
  logic              arm;
  logic              disarm;
  logic              irq_ack;

  logic              irq;
  logic [1:0]        state;
  logic [MCNT_W-1:0] match_count;
  logic              missed;
  logic [CNT_W-1:0]  target;

  modport master (
    output cmp_wdata, cmp_load, period, periodic, arm, disarm, irq_ack,
    input  irq, state, match_count, missed, target
  );

  modport slave (
    input  cmp_wdata, cmp_load, period, periodic, arm, disarm, irq_ack,
    output irq, state, match_count, missed, target
  );

endinterface

// File: rtl/timer_alarm_cmp.sv
// Wrap-safe "a has reached b" comparator: true when (a - b) mod 2^W is non-negative as a signed value.
module timer_alarm_cmp #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         reached
);

  logic         diff_sign;
  logic [W-2:0] diff_low_unused;

  assign {diff_sign, diff_low_unused} = a - b;
  assign reached = ~diff_sign;

endmodule

// File: rtl/timer_alarm.sv
// Compare/alarm stage behind the 64-bit free-running timer; raises a level irq when the counter reaches target.
// Periodic auto-reload with overrun detection is compiled in only when TIMER_ALARM_PERIODIC_EN is defined.
module timer_alarm
  import timer_alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_value,
  timer_alarm_if.slave     bus
);

  state_e              state_q, state_d;
  logic                irq_q, irq_d;
  logic                missed_q, missed_d;
  logic                mode_q, mode_d;
  logic [MCNT_W-1:0]   match_count_q, match_count_d;
  logic [CNT_W-1:0]    target_q, target_d;

  logic                reached;
  logic                hit;
  logic                reload;
  logic                overrun;
  logic                periodic_in;
  logic [CNT_W-1:0]    reload_target;

  timer_alarm_cmp #(.W(CNT_W)) u_hit_cmp (
    .a       (cnt_value),
    .b       (target_q),
    .reached (reached)
  );

  // A hit only takes effect when neither arm nor disarm claims the cycle.
  assign hit = (state_q == ST_ARMED) && reached && !bus.arm && !bus.disarm;

`ifdef TIMER_ALARM_PERIODIC_EN
  assign periodic_in   = bus.periodic;
  assign reload_target = target_q + bus.period;
  assign reload        = mode_q && (bus.period != '0);

  timer_alarm_cmp #(.W(CNT_W)) u_ovr_cmp (
    .a       (cnt_value),
    .b       (reload_target),
    .reached (overrun)
  );
`else
  logic periodic_unused;

  assign periodic_unused = ^{bus.periodic, bus.period};
  assign periodic_in     = 1'b0;
  assign reload_target   = target_q;
  assign reload          = mode_q;
  assign overrun         = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    irq_d         = irq_q;
    missed_d      = missed_q;
    mode_d        = mode_q;
    match_count_d = match_count_q;
    target_d      = target_q;

    if (bus.disarm) begin
      state_d = ST_IDLE;
    end else if (bus.arm) begin
      state_d = ST_ARMED;
      mode_d  = periodic_in;
    end else begin
      case (state_q)
        ST_ARMED: if (hit) state_d = reload ? ST_ARMED : ST_FIRED;
        ST_FIRED: if (bus.irq_ack) state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end

    // A fresh hit keeps irq high even when acknowledged in the same cycle; missed is always cleared by ack.
    if (hit) begin
      irq_d = 1'b1;
    end else if (bus.irq_ack) begin
      irq_d = 1'b0;
    end

    if (bus.irq_ack) begin
      missed_d = 1'b0;
    end else if (hit && reload && overrun) begin
      missed_d = 1'b1;
    end

    if (hit) begin
      match_count_d = sat_inc(match_count_q);
    end

    if (bus.cmp_load) begin
      target_d = bus.cmp_wdata;
    end else if (hit && reload) begin
      target_d = reload_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      irq_q         <= 1'b0;
      missed_q      <= 1'b0;
      mode_q        <= 1'b0;
      match_count_q <= '0;
      target_q      <= '1;
    end else begin
      state_q       <= state_d;
      irq_q         <= irq_d;
      missed_q      <= missed_d;
      mode_q        <= mode_d;
      match_count_q <= match_count_d;
      target_q      <= target_d;
    end
  end

  assign bus.irq         = irq_q;
  assign bus.state       = state_q;
  assign bus.match_count = match_count_q;
  assign bus.missed      = missed_q;
  assign bus.target      = target_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: directed scenarios plus randomized traffic against a reference model.
// Honours TIMER_ALARM_PERIODIC_EN the same way the design does.
module tb_timer_alarm;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cnt_value;
  logic [63:0] cnt;

  timer_alarm_if bus ();

  timer_alarm dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_value (cnt_value),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state, kept as plain values (state: 0 idle, 1 armed, 2 fired)
  logic [63:0] mTarget;
  logic [1:0]  mState;
  logic        mIrq;
  logic        mMissed;
  logic        mMode;
  logic [15:0] mCount;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mTarget = 64'hFFFF_FFFF_FFFF_FFFF;
    mState  = 2'd0;
    mIrq    = 1'b0;
    mMissed = 1'b0;
    mMode   = 1'b0;
    mCount  = 16'd0;
  endtask

  task automatic modelStep(input bit a, input bit d, input bit ack, input bit ld);
    bit          hit;
    bit          reloading;
    bit          overrun;
    logic [63:0] nextTarget;
    hit = (mState == 2'd1) && (longint'(cnt_value - mTarget) >= 0) && !a && !d;
`ifdef TIMER_ALARM_PERIODIC_EN
    reloading = mMode && (bus.period != 64'd0);
`else
    reloading = 1'b0;
`endif
    nextTarget = mTarget + bus.period;
    overrun    = reloading && (longint'(cnt_value - nextTarget) >= 0);

    if (d) begin
      mState = 2'd0;
    end else if (a) begin
      mState = 2'd1;
`ifdef TIMER_ALARM_PERIODIC_EN
      mMode = bus.periodic;
`else
      mMode = 1'b0;
`endif
    end else if (hit) begin
      if (!reloading) mState = 2'd2;
    end else if (mState == 2'd2 && ack) begin
      mState = 2'd0;
    end

    mIrq    = hit ? 1'b1 : (ack ? 1'b0 : mIrq);
    mMissed = ack ? 1'b0 : ((hit && overrun) ? 1'b1 : mMissed);
    if (hit && mCount != 16'hFFFF) mCount = mCount + 16'd1;
    if (ld) mTarget = bus.cmp_wdata;
    else if (hit && reloading) mTarget = nextTarget;
  endtask

  task automatic compareAll();
    checkOutput("irq",         64'(bus.irq),         64'(mIrq));
    checkOutput("state",       64'(bus.state),       64'(mState));
    checkOutput("match_count", 64'(bus.match_count), 64'(mCount));
    checkOutput("missed",      64'(bus.missed),      64'(mMissed));
    checkOutput("target",      bus.target,           mTarget);
  endtask

  // One clock: drive pulses with the current counter value, step the model on the edge, compare 1 ns later.
  task automatic applyStimulus(input bit a, input bit d, input bit ack, input bit ld);
    cnt_value    = cnt;
    bus.arm      = a;
    bus.disarm   = d;
    bus.irq_ack  = ack;
    bus.cmp_load = ld;
    @(posedge clk);
    modelStep(a, d, ack, ld);
    #1;
    compareAll();
    bus.arm      = 1'b0;
    bus.disarm   = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.cmp_load = 1'b0;
  endtask

  task automatic runCycles(input int n, input logic [63:0] step);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      cnt = cnt + step;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_irq"},    64'(bus.irq),         64'd0);
    checkOutput({tag, "_state"},  64'(bus.state),       64'd0);
    checkOutput({tag, "_count"},  64'(bus.match_count), 64'd0);
    checkOutput({tag, "_missed"}, 64'(bus.missed),      64'd0);
    checkOutput({tag, "_target"}, bus.target,           64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    cnt           = 64'd0;
    cnt_value     = 64'd0;
    bus.cmp_wdata = 64'd0;
    bus.cmp_load  = 1'b0;
    bus.period    = 64'd0;
    bus.periodic  = 1'b0;
    bus.arm       = 1'b0;
    bus.disarm    = 1'b0;
    bus.irq_ack   = 1'b0;
    modelReset();

    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b1;

    // One-shot: target 100, armed at 90
    cnt = 64'd89;
    bus.cmp_wdata = 64'd100;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    runCycles(9, 64'd1);
    checkOutput("oneshot_early_irq", 64'(bus.irq), 64'd0);
    runCycles(1, 64'd1);
    checkOutput("oneshot_irq",   64'(bus.irq),         64'd1);
    checkOutput("oneshot_state", 64'(bus.state),       64'd2);
    checkOutput("oneshot_count", 64'(bus.match_count), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;
    checkOutput("oneshot_ack_irq",   64'(bus.irq),   64'd0);
    checkOutput("oneshot_ack_state", 64'(bus.state), 64'd0);

    // Counter wrap: target 5, armed just below the top of the range
    cnt = 64'hFFFF_FFFF_FFFF_FFEF;
    bus.cmp_wdata = 64'd5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    runCycles(20, 64'd1);
    checkOutput("wrap_early_irq", 64'(bus.irq), 64'd0);
    runCycles(1, 64'd1);
    checkOutput("wrap_irq",   64'(bus.irq),   64'd1);
    checkOutput("wrap_state", 64'(bus.state), 64'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;

    // arm and disarm together: disarm wins
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); cnt = cnt + 64'd1;
    checkOutput("arm_disarm_state", 64'(bus.state), 64'd0);

    // Hit coinciding with irq_ack while irq is already high
    bus.cmp_wdata = cnt + 64'd3;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    runCycles(2, 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;
    checkOutput("hit_ack_irq",   64'(bus.irq),         64'd1);
    checkOutput("hit_ack_count", 64'(bus.match_count), 64'd4);
    checkOutput("hit_ack_state", 64'(bus.state),       64'd2);

    // Reset while armed with irq high
    bus.cmp_wdata = cnt + 64'd1000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    checkOutput("pre_reset_irq",   64'(bus.irq),   64'd1);
    checkOutput("pre_reset_state", 64'(bus.state), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset_hold_irq", 64'(bus.irq), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    runCycles(5, 64'd1);

`ifdef TIMER_ALARM_PERIODIC_EN
    // Periodic: target 50, period 20 -> hits at 50, 70, 90
    cnt = 64'd40;
    bus.cmp_wdata = 64'd50;
    bus.period    = 64'd20;
    bus.periodic  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    runCycles(59, 64'd1);
    checkOutput("periodic_target", bus.target,           64'd110);
    checkOutput("periodic_count",  64'(bus.match_count), 64'd3);
    checkOutput("periodic_missed", 64'(bus.missed),      64'd0);
    checkOutput("periodic_state",  64'(bus.state),       64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); cnt = cnt + 64'd1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;

    // Overrun: period 1, counter held and then stepped past target+period
    bus.period    = 64'd1;
    bus.cmp_wdata = cnt + 64'd2;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runCycles(3, 64'd0);
    cnt = cnt + 64'd3;
    runCycles(3, 64'd1);
    checkOutput("overrun_missed", 64'(bus.missed), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;
    checkOutput("overrun_ack_missed", 64'(bus.missed), 64'd0);
    checkOutput("overrun_ack_irq",    64'(bus.irq),    64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); cnt = cnt + 64'd1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;
`else
    // Periodic request with the feature compiled out behaves as one-shot
    bus.periodic  = 1'b1;
    bus.period    = 64'd20;
    bus.cmp_wdata = cnt + 64'd2;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); cnt = cnt + 64'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); cnt = cnt + 64'd1;
    runCycles(3, 64'd1);
    checkOutput("noperiodic_state",  64'(bus.state),  64'd2);
    checkOutput("noperiodic_missed", 64'(bus.missed), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); cnt = cnt + 64'd1;
`endif
    bus.periodic = 1'b0;

    // Randomized traffic near the target, including occasional jumps to just below the wrap point
    for (int i = 0; i < 400; i++) begin
      bit a;
      bit d;
      bit ack;
      bit ld;
      a   = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 31) == 0);
      ack = ($urandom_range(0, 7) == 0);
      ld  = ($urandom_range(0, 11) == 0);
      if (ld) bus.cmp_wdata = cnt + 64'($urandom_range(0, 30)) - 64'd5;
      if ($urandom_range(0, 9) == 0) begin
        bus.period   = 64'($urandom_range(0, 6));
        bus.periodic = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) == 0) cnt = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 16));
      applyStimulus(a, d, ack, ld);
      cnt = cnt + 64'($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
